// File: rtl/vdata_pkg.sv
// Shared widths and requester tag for the video ROM arbiter.
package vdata_pkg;

  localparam int unsigned ROM_AW = 12;
  localparam int unsigned ROM_DW = 8;

  typedef enum logic {
    REQ_CHAR = 1'b0,
    REQ_SPR  = 1'b1
  } req_tag_e;

endpackage

// File: rtl/vrom_tag_pipe.sv
// Valid/tag shift register that follows each ROM read from grant to capture.
// DEPTH is ROM_LAT+1 so the last stage lines up with the ROM output.
module vrom_tag_pipe
  import vdata_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk_sys,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     in_vld,
  input  req_tag_e in_tag,
  output logic     out_vld,
  output req_tag_e out_tag,
  output logic     any_vld
);

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_tag;

  // Shift valid/tag one stage per clock; flush drops every in-flight entry.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_tag <= '0;
    end else begin
      r_tag <= {r_tag[DEPTH-2:0], in_tag};
      if (flush) begin
        r_vld <= '0;
      end else begin
        r_vld <= {r_vld[DEPTH-2:0], in_vld};
      end
    end
  end

  assign out_vld = r_vld[DEPTH-1];
  assign out_tag = req_tag_e'(r_tag[DEPTH-1]);
  assign any_vld = |r_vld;

endmodule

// File: rtl/vrom_arbiter.sv
// Shared video ROM port arbiter for the char and sprite fetchers.
// Default build: round-robin on contention.
// VROM_ARB_SPR_PRIO_EN defined: sprite has fixed priority on contention.
module vrom_arbiter
  import vdata_pkg::*;
#(
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              ioctl_download,
  input  logic              char_req,
  input  logic [ROM_AW-1:0] char_addr,
  output logic              char_ack,
  output logic              char_valid,
  output logic [ROM_DW-1:0] char_data1,
  output logic [ROM_DW-1:0] char_data2,
  input  logic              spr_req,
  input  logic [ROM_AW-1:0] spr_addr,
  output logic              spr_ack,
  output logic              spr_valid,
  output logic [ROM_DW-1:0] spr_data1,
  output logic [ROM_DW-1:0] spr_data2,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROM_DW-1:0] rom_q1,
  input  logic [ROM_DW-1:0] rom_q2,
  output logic              busy
);

  localparam int unsigned PIPE_D = ROM_LAT + 1;

  logic              r_char_ack;
  logic              r_spr_ack;
  logic              r_char_valid;
  logic              r_spr_valid;
  logic [ROM_DW-1:0] r_char_data1;
  logic [ROM_DW-1:0] r_char_data2;
  logic [ROM_DW-1:0] r_spr_data1;
  logic [ROM_DW-1:0] r_spr_data2;
  logic [ROM_AW-1:0] r_rom_addr;
  req_tag_e          r_last;

  logic              w_char_elig;
  logic              w_spr_elig;
  logic              w_gnt_char;
  logic              w_gnt_spr;
  logic              w_gnt;
  req_tag_e          w_gnt_tag;
  logic [ROM_AW-1:0] w_gnt_addr;
  logic              w_pipe_vld;
  req_tag_e          w_pipe_tag;
  logic              w_pipe_any;
  logic              w_done_char;
  logic              w_done_spr;

  // Grant decision: a requester is eligible unless it was acked last cycle.
  always_comb begin
    w_char_elig = char_req & ~r_char_ack;
    w_spr_elig  = spr_req & ~r_spr_ack;
    w_gnt_char  = 1'b0;
    w_gnt_spr   = 1'b0;
    if (!ioctl_download) begin
      if (w_char_elig && w_spr_elig) begin
`ifdef VROM_ARB_SPR_PRIO_EN
        w_gnt_spr = 1'b1;
`else
        if (r_last == REQ_SPR) begin
          w_gnt_char = 1'b1;
        end else begin
          w_gnt_spr = 1'b1;
        end
`endif
      end else if (w_char_elig) begin
        w_gnt_char = 1'b1;
      end else if (w_spr_elig) begin
        w_gnt_spr = 1'b1;
      end
    end
    w_gnt      = w_gnt_char | w_gnt_spr;
    w_gnt_tag  = w_gnt_spr ? REQ_SPR : REQ_CHAR;
    w_gnt_addr = w_gnt_spr ? spr_addr : char_addr;
  end

  vrom_tag_pipe #(
    .DEPTH (PIPE_D)
  ) u_tag_pipe (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .flush   (ioctl_download),
    .in_vld  (w_gnt),
    .in_tag  (w_gnt_tag),
    .out_vld (w_pipe_vld),
    .out_tag (w_pipe_tag),
    .any_vld (w_pipe_any)
  );

  // A read completes only if no download is cutting it off this cycle.
  always_comb begin
    w_done_char = w_pipe_vld & ~ioctl_download & (w_pipe_tag == REQ_CHAR);
    w_done_spr  = w_pipe_vld & ~ioctl_download & (w_pipe_tag == REQ_SPR);
  end

  // Ack, address, last-grant pointer and per-requester result registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_char_ack   <= 1'b0;
      r_spr_ack    <= 1'b0;
      r_char_valid <= 1'b0;
      r_spr_valid  <= 1'b0;
      r_char_data1 <= '0;
      r_char_data2 <= '0;
      r_spr_data1  <= '0;
      r_spr_data2  <= '0;
      r_rom_addr   <= '0;
      r_last       <= REQ_SPR;
    end else begin
      r_char_ack   <= w_gnt_char;
      r_spr_ack    <= w_gnt_spr;
      r_char_valid <= w_done_char;
      r_spr_valid  <= w_done_spr;
      if (w_gnt) begin
        r_rom_addr <= w_gnt_addr;
        r_last     <= w_gnt_tag;
      end
      if (w_done_char) begin
        r_char_data1 <= rom_q1;
        r_char_data2 <= rom_q2;
      end
      if (w_done_spr) begin
        r_spr_data1 <= rom_q1;
        r_spr_data2 <= rom_q2;
      end
    end
  end

  assign char_ack   = r_char_ack;
  assign spr_ack    = r_spr_ack;
  assign char_valid = r_char_valid;
  assign spr_valid  = r_spr_valid;
  assign char_data1 = r_char_data1;
  assign char_data2 = r_char_data2;
  assign spr_data1  = r_spr_data1;
  assign spr_data2  = r_spr_data2;
  assign rom_addr   = r_rom_addr;
  assign busy       = rst_n & (w_pipe_any | ioctl_download);

endmodule

// File: tb/tb_vrom_arbiter.sv
// Self-checking bench for vrom_arbiter (ROM_LAT=1 main instance, ROM_LAT=3 reset instance).
module tb_vrom_arbiter;
  import vdata_pkg::*;

  localparam int unsigned LAT1 = 1;
  localparam int unsigned LAT3 = 3;
`ifdef VROM_ARB_SPR_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic        rst_n, ioctl, char_req, spr_req;
  logic [11:0] char_addr, spr_addr, rom_addr;
  logic        char_ack, char_valid, spr_ack, spr_valid, busy;
  logic [7:0]  char_data1, char_data2, spr_data1, spr_data2, rom_q1, rom_q2;

  // ROM_LAT=3 instance signals
  logic        rst3_n, ioctl3, char_req3, spr_req3;
  logic [11:0] char_addr3, spr_addr3, rom_addr3;
  logic        char_ack3, char_valid3, spr_ack3, spr_valid3, busy3;
  logic [7:0]  char_data1_3, char_data2_3, spr_data1_3, spr_data2_3, rom_q1_3, rom_q2_3;

  vrom_arbiter #(.ROM_LAT(LAT1)) u_dut (
    .clk_sys(clk), .rst_n(rst_n), .ioctl_download(ioctl),
    .char_req(char_req), .char_addr(char_addr), .char_ack(char_ack), .char_valid(char_valid),
    .char_data1(char_data1), .char_data2(char_data2),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_valid(spr_valid),
    .spr_data1(spr_data1), .spr_data2(spr_data2),
    .rom_addr(rom_addr), .rom_q1(rom_q1), .rom_q2(rom_q2), .busy(busy)
  );

  vrom_arbiter #(.ROM_LAT(LAT3)) u_dut3 (
    .clk_sys(clk), .rst_n(rst3_n), .ioctl_download(ioctl3),
    .char_req(char_req3), .char_addr(char_addr3), .char_ack(char_ack3), .char_valid(char_valid3),
    .char_data1(char_data1_3), .char_data2(char_data2_3),
    .spr_req(spr_req3), .spr_addr(spr_addr3), .spr_ack(spr_ack3), .spr_valid(spr_valid3),
    .spr_data1(spr_data1_3), .spr_data2(spr_data2_3),
    .rom_addr(rom_addr3), .rom_q1(rom_q1_3), .rom_q2(rom_q2_3), .busy(busy3)
  );

  // ROM contents as a function of address
  function automatic logic [7:0] f1(input logic [11:0] a);
    return a[7:0] ^ {4'h0, a[11:8]} ^ 8'h87;
  endfunction
  function automatic logic [7:0] f2(input logic [11:0] a);
    return {a[3:0], a[7:4]} ^ {a[11:8], 4'h0} ^ 8'h78;
  endfunction

  // ROM models with ROM_LAT clock latency
  logic [11:0] ra1_d;
  logic [11:0] ra3_d [3];
  always_ff @(posedge clk) begin
    ra1_d    <= rom_addr;
    ra3_d[0] <= rom_addr3;
    ra3_d[1] <= ra3_d[0];
    ra3_d[2] <= ra3_d[1];
  end
  assign rom_q1   = f1(ra1_d);
  assign rom_q2   = f2(ra1_d);
  assign rom_q1_3 = f1(ra3_d[2]);
  assign rom_q2_3 = f2(ra3_d[2]);

  typedef struct {
    logic       tag;
    logic [7:0] d1;
    logic [7:0] d2;
    int         due;
  } exp_t;

  typedef struct {
    logic creq;
    logic sreq;
    logic cack;
    logic sack;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: push on ack, pop and compare on valid
  task automatic sb_step();
    exp_t e;
    if (mon_en && char_ack)
      sb.push_back('{tag: 1'b0, d1: f1(char_addr), d2: f2(char_addr), due: cyc + int'(LAT1) + 1});
    if (mon_en && spr_ack)
      sb.push_back('{tag: 1'b1, d1: f1(spr_addr), d2: f2(spr_addr), due: cyc + int'(LAT1) + 1});
    if (char_valid || spr_valid) begin
      check("sb_one_valid", 32'(char_valid & spr_valid), 32'd0);
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("sb_tag", 32'(spr_valid), 32'(e.tag));
        check("sb_d1", 32'(spr_valid ? spr_data1 : char_data1), 32'(e.d1));
        check("sb_d2", 32'(spr_valid ? spr_data2 : char_data2), 32'(e.d2));
        check("sb_latency", 32'(cyc), 32'(e.due));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    sb_step();
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    ioctl    = 1'b0;
    char_req = 1'b0;
    spr_req  = 1'b0;
    sb.delete();
    repeat (2) tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      char_req = vecs[i].creq;
      spr_req  = vecs[i].sreq;
      tick();
      check($sformatf("%s_v%0d_char_ack", tag, i), 32'(char_ack), 32'(vecs[i].cack));
      check($sformatf("%s_v%0d_spr_ack", tag, i), 32'(spr_ack), 32'(vecs[i].sack));
      if (char_ack) char_addr = char_addr + 12'd1;
      if (spr_ack)  spr_addr  = spr_addr + 12'd7;
    end
    char_req = 1'b0;
    spr_req  = 1'b0;
    check($sformatf("%s_sb_drained", tag), 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ioctl = 1'b0; char_req = 1'b0; spr_req = 1'b0;
    char_addr = '0; spr_addr = '0;
    rst3_n = 1'b0; ioctl3 = 1'b0; char_req3 = 1'b0; spr_req3 = 1'b0;
    char_addr3 = '0; spr_addr3 = '0;
    repeat (3) tick();

    // Reset state
    check("rst_rom_addr", 32'(rom_addr), 32'h000);
    check("rst_char_ack", 32'(char_ack), 32'd0);
    check("rst_spr_valid", 32'(spr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_char_data1", 32'(char_data1), 32'h00);
    check("rst_spr_data2", 32'(spr_data2), 32'h00);
    check("rst3_rom_addr", 32'(rom_addr3), 32'h000);
    rst_n = 1'b1;
    rst3_n = 1'b1;

    // Single char read, fixed data
    mon_en = 1'b1;
    char_addr = 12'h123;
    char_req = 1'b1;
    tick();
    check("one_ack", 32'(char_ack), 32'd1);
    check("one_rom_addr", 32'(rom_addr), 32'h123);
    char_req = 1'b0;
    tick();
    check("one_ack_pulse", 32'(char_ack), 32'd0);
    check("one_valid_early", 32'(char_valid), 32'd0);
    tick();
    check("one_valid", 32'(char_valid), 32'd1);
    check("one_data1", 32'(char_data1), 32'hA5);
    check("one_data2", 32'(char_data2), 32'h5A);
    check("one_spr_valid", 32'(spr_valid), 32'd0);
    tick();
    check("one_valid_pulse", 32'(char_valid), 32'd0);
    check("one_data_hold", 32'(char_data1), 32'hA5);
    check("one_busy_idle", 32'(busy), 32'd0);

    // Both requesters held: alternating grants on consecutive edges
    do_reset();
    char_addr = 12'h040;
    spr_addr  = 12'h800;
    vecs.delete();
    for (int i = 0; i < 8; i++) begin
      vecs.push_back('{creq: 1'b1, sreq: 1'b1,
                       cack: ((i % 2) == 0) != PRIO, sack: ((i % 2) == 0) == PRIO});
    end
    for (int i = 0; i < 5; i++) vecs.push_back('{creq: 1'b0, sreq: 1'b0, cack: 1'b0, sack: 1'b0});
    run_vecs("both");

    // Single held char requester: one grant every 2 cycles
    do_reset();
    char_addr = 12'h100;
    vecs.delete();
    for (int i = 0; i < 8; i++) begin
      vecs.push_back('{creq: 1'b1, sreq: 1'b0, cack: (i % 2) == 0, sack: 1'b0});
    end
    for (int i = 0; i < 4; i++) vecs.push_back('{creq: 1'b0, sreq: 1'b0, cack: 1'b0, sack: 1'b0});
    run_vecs("single");

    // Download cuts off an in-flight read
    do_reset();
    char_addr = 12'h0F0;
    spr_addr  = 12'h0A0;
    char_req  = 1'b1;
    mon_en    = 1'b0;
    tick();
    check("dl_first_ack", 32'(char_ack), 32'd1);
    ioctl    = 1'b1;
    spr_req  = 1'b1;
    #1;
    check("dl_busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("dl%0d_busy", i), 32'(busy), 32'd1);
      check($sformatf("dl%0d_acks", i), 32'({char_ack, spr_ack}), 32'd0);
      check($sformatf("dl%0d_valids", i), 32'({char_valid, spr_valid}), 32'd0);
    end
    ioctl  = 1'b0;
    mon_en = 1'b1;
    tick();
    check("dl_regrant_spr", 32'(spr_ack), 32'd1);
    check("dl_regrant_char", 32'(char_ack), 32'd0);
    char_req = 1'b0;
    spr_req  = 1'b0;
    repeat (4) tick();
    check("dl_char_data_kept", 32'(char_data1), 32'h00);
    check("dl_sb_drained", 32'(sb.size()), 32'd0);

    // ROM_LAT=3: complete read, then reset mid-read
    char_addr3 = 12'h3C5;
    char_req3  = 1'b1;
    tick();
    check("l3_ack", 32'(char_ack3), 32'd1);
    char_req3 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("l3_valid_k%0d", k), 32'(char_valid3), 32'(k == 4));
    end
    check("l3_data1", 32'(char_data1_3), 32'(f1(12'h3C5)));
    check("l3_data2", 32'(char_data2_3), 32'(f2(12'h3C5)));
    char_addr3 = 12'h2AB;
    char_req3  = 1'b1;
    tick();
    check("l3_ack2", 32'(char_ack3), 32'd1);
    char_req3 = 1'b0;
    tick();
    check("l3_busy_inflight", 32'(busy3), 32'd1);
    #2;
    rst3_n = 1'b0;
    #1;
    check("l3r_data1", 32'(char_data1_3), 32'h00);
    check("l3r_data2", 32'(char_data2_3), 32'h00);
    check("l3r_rom_addr", 32'(rom_addr3), 32'h000);
    check("l3r_busy", 32'(busy3), 32'd0);
    check("l3r_ack_valid", 32'({char_ack3, char_valid3, spr_ack3, spr_valid3}), 32'd0);
    char_req3  = 1'b1;
    spr_req3   = 1'b1;
    char_addr3 = 12'h155;
    spr_addr3  = 12'h2EE;
    repeat (2) tick();
    check("l3r_no_ack_in_reset", 32'({char_ack3, spr_ack3}), 32'd0);
    rst3_n = 1'b1;
    tick();
    check("l3r_first_char", 32'(char_ack3), 32'd1);
    check("l3r_first_spr", 32'(spr_ack3), 32'd0);
    check("l3r_first_addr", 32'(rom_addr3), 32'h155);
    char_req3 = 1'b0;
    spr_req3  = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("l3r_valid_k%0d", k), 32'(char_valid3), 32'(k == 4));
      check($sformatf("l3r_spr_valid_k%0d", k), 32'(spr_valid3), 32'd0);
      if (k == 4) check("l3r_data1", 32'(char_data1_3), 32'(f1(12'h155)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
